// File: rtl/pixel_stream_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pixel_stream_gen: black frames with one white box, IPU-style pixel bus.  |
// | Optional PATTERN_MOTION_EN bounces the box horizontally. Rev 1.0         |
// +--------------------------------------------------------------------------+
module pixel_stream_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 160,
  parameter int V_ACTIVE = 480,
  parameter int V_BLANK  = 45,
  parameter int COLOR_W  = 12,
  parameter int COORD_W  = 11
`ifdef PATTERN_MOTION_EN
  ,
  parameter int STEP     = 4
`endif
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iStart,
  input  logic               iStop,
  input  logic [7:0]         iNumFrames,
  input  logic [COORD_W-1:0] iBoxX,
  input  logic [COORD_W-1:0] iBoxY,
  input  logic [COORD_W-1:0] iBoxW,
  input  logic [COORD_W-1:0] iBoxH,
  output logic               oDVAL,
  output logic [COLOR_W-1:0] oRed,
  output logic [COLOR_W-1:0] oGreen,
  output logic [COLOR_W-1:0] oBlue,
  output logic [COORD_W-1:0] oX_Cont,
  output logic [COORD_W-1:0] oY_Cont,
  output logic               oFrameDone,
  output logic               oBusy
);

  localparam int CW1 = COORD_W + 1;
  localparam logic [COORD_W-1:0] H_ACT_LAST = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] H_LAST     = COORD_W'(H_ACTIVE + H_BLANK - 1);
  localparam logic [COORD_W-1:0] V_ACT_LAST = COORD_W'(V_ACTIVE - 1);
  localparam logic [COORD_W-1:0] V_LAST     = COORD_W'(V_ACTIVE + V_BLANK - 1);
`ifdef PATTERN_MOTION_EN
  localparam logic [CW1-1:0] STEP_X  = CW1'(STEP);
  localparam logic [CW1-1:0] H_ACT_X = CW1'(H_ACTIVE);
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_HBLANK = 2'd2,
    S_VBLANK = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic [COORD_W-1:0] h_q, h_d, v_q, v_d;
  logic [7:0] frames_q, frames_d, num_q, num_d;
  logic stop_q, stop_d;
  logic [COORD_W-1:0] box_x_q, box_x_d, box_y_q, box_y_d;
  logic [COORD_W-1:0] box_w_q, box_w_d, box_h_q, box_h_d;
`ifdef PATTERN_MOTION_EN
  logic dir_q, dir_d;  // 1 = moving toward smaller X
`endif

  logic dval_q, dval_d, white_q, white_d, done_q, done_d, busy_q, busy_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [CW1-1:0] x_e, y_e;

  always_comb begin
    state_d  = state_q;
    h_d      = h_q;
    v_d      = v_q;
    frames_d = frames_q;
    num_d    = num_q;
    stop_d   = stop_q | (iStop & (state_q != S_IDLE));
    box_x_d  = box_x_q;
    box_y_d  = box_y_q;
    box_w_d  = box_w_q;
    box_h_d  = box_h_q;
`ifdef PATTERN_MOTION_EN
    dir_d    = dir_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          state_d  = S_ACTIVE;
          h_d      = '0;
          v_d      = '0;
          frames_d = '0;
          num_d    = iNumFrames;
          box_x_d  = iBoxX;
          box_y_d  = iBoxY;
          box_w_d  = iBoxW;
          box_h_d  = iBoxH;
`ifdef PATTERN_MOTION_EN
          dir_d    = 1'b0;
`endif
        end
      end
      S_ACTIVE: begin
        h_d = h_q + 1'b1;
        if (h_q == H_ACT_LAST) state_d = S_HBLANK;
      end
      S_HBLANK: begin
        if (h_q == H_LAST) begin
          h_d     = '0;
          v_d     = v_q + 1'b1;
          state_d = (v_q == V_ACT_LAST) ? S_VBLANK : S_ACTIVE;
        end else begin
          h_d = h_q + 1'b1;
        end
      end
      S_VBLANK: begin
        if (h_q == H_LAST) begin
          h_d = '0;
          if (v_q == V_LAST) begin
            v_d      = '0;
            frames_d = frames_q + 8'd1;
            if (stop_d || ((num_q != 8'd0) && (frames_d == num_q))) begin
              state_d = S_IDLE;
            end else begin
              // Back-to-back frame: the box is re-sampled at this boundary only.
              state_d = S_ACTIVE;
              box_y_d = iBoxY;
              box_w_d = iBoxW;
              box_h_d = iBoxH;
`ifdef PATTERN_MOTION_EN
              if (!dir_q) begin
                if (({1'b0, box_x_q} + {1'b0, iBoxW} + STEP_X) > H_ACT_X) begin
                  dir_d   = 1'b1;
                  box_x_d = (box_x_q >= STEP_X[COORD_W-1:0]) ?
                            box_x_q - STEP_X[COORD_W-1:0] : box_x_q;
                end else begin
                  box_x_d = box_x_q + STEP_X[COORD_W-1:0];
                end
              end else if (box_x_q < STEP_X[COORD_W-1:0]) begin
                dir_d   = 1'b0;
                box_x_d = box_x_q + STEP_X[COORD_W-1:0];
              end else begin
                box_x_d = box_x_q - STEP_X[COORD_W-1:0];
              end
`else
              box_x_d = iBoxX;
`endif
            end
          end else begin
            v_d = v_q + 1'b1;
          end
        end else begin
          h_d = h_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) stop_d = 1'b0;

    // Outputs describe the cycle being entered, so they come from the _d side.
    dval_d  = (state_d == S_ACTIVE);
    x_d     = dval_d ? h_d : '0;
    y_d     = dval_d ? v_d : '0;
    x_e     = {1'b0, h_d};
    y_e     = {1'b0, v_d};
    white_d = dval_d &&
              (x_e >= {1'b0, box_x_d}) && (x_e < ({1'b0, box_x_d} + {1'b0, box_w_d})) &&
              (y_e >= {1'b0, box_y_d}) && (y_e < ({1'b0, box_y_d} + {1'b0, box_h_d}));
    done_d  = (state_d == S_VBLANK) && (h_d == H_LAST) && (v_d == V_LAST);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q  <= S_IDLE;
      h_q      <= '0;
      v_q      <= '0;
      frames_q <= '0;
      num_q    <= '0;
      stop_q   <= 1'b0;
      box_x_q  <= '0;
      box_y_q  <= '0;
      box_w_q  <= '0;
      box_h_q  <= '0;
`ifdef PATTERN_MOTION_EN
      dir_q    <= 1'b0;
`endif
      dval_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      white_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      h_q      <= h_d;
      v_q      <= v_d;
      frames_q <= frames_d;
      num_q    <= num_d;
      stop_q   <= stop_d;
      box_x_q  <= box_x_d;
      box_y_q  <= box_y_d;
      box_w_q  <= box_w_d;
      box_h_q  <= box_h_d;
`ifdef PATTERN_MOTION_EN
      dir_q    <= dir_d;
`endif
      dval_q   <= dval_d;
      x_q      <= x_d;
      y_q      <= y_d;
      white_q  <= white_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign oDVAL      = dval_q;
  assign oRed       = {COLOR_W{white_q}};
  assign oGreen     = {COLOR_W{white_q}};
  assign oBlue      = {COLOR_W{white_q}};
  assign oX_Cont    = x_q;
  assign oY_Cont    = y_q;
  assign oFrameDone = done_q;
  assign oBusy      = busy_q;

endmodule
`default_nettype wire
